// File: rtl/fp_mult_pkg.sv
// Shared definitions for the fp_multiplier normalize/round back end.
// Holds operand class encodings, the canonical quiet NaN, the largest
// biased exponent, flag bit positions and the stage-1 register layout.
// Optional feature macro used by the importing files: FP_MULT_SUBNORM_EN.
package fp_mult_pkg;

    // Operand class carried alongside the raw product.
    localparam logic [1:0] CLS_NORM = 2'b00;
    localparam logic [1:0] CLS_ZERO = 2'b01;
    localparam logic [1:0] CLS_INF  = 2'b10;
    localparam logic [1:0] CLS_INV  = 2'b11;

    localparam logic [31:0]        QNAN    = 32'h7FC0_0000;
    localparam logic signed [10:0] EXP_MAX = 11'sd255;

    // Bit positions inside out_flags = {invalid, overflow, underflow, inexact}.
    localparam int FLG_INV = 3;
    localparam int FLG_OVF = 2;
    localparam int FLG_UDF = 1;
    localparam int FLG_INX = 0;

    // Normalized (and, with gradual underflow, denormalized) beat between stages.
    typedef struct packed {
        logic               sign;
        logic [1:0]         cls;
        logic signed [9:0]  exp;
        logic [22:0]        frac;
        logic               guard;
        logic               sticky;
    } s1_t;

endpackage

// File: rtl/fp_mult_norm_round_rne.sv
// fp_rne_round: combinational round-to-nearest-even of a 23-bit fraction.
// Ports:
//   frac     in  23  truncated fraction
//   guard    in  1   first bit below the fraction LSB
//   sticky   in  1   OR of every bit below guard
//   frac_rnd out 23  rounded fraction (wraps to 0 on carry)
//   carry    out 1   carry out of the fraction MSB
// Not affected by FP_MULT_SUBNORM_EN.
module fp_rne_round (
    input  logic [22:0] frac,
    input  logic        guard,
    input  logic        sticky,
    output logic [22:0] frac_rnd,
    output logic        carry
);
    import fp_mult_pkg::*;

    logic        inc_s;
    logic [23:0] sum_s;

    // Ties go to the even fraction: round up only above half, or at half with odd LSB.
    assign inc_s    = guard & (sticky | frac[0]);
    assign sum_s    = {1'b0, frac} + {23'd0, inc_s};
    assign frac_rnd = sum_s[22:0];
    assign carry    = sum_s[23];

endmodule

// File: rtl/fp_mult_norm_round.sv
// fp_mult_norm_round: two-stage valid/ready back end of fp_multiplier.
// Stage 1 normalizes the 48-bit significand product; stage 2 rounds to
// nearest-even and resolves overflow, underflow and special classes into an
// IEEE-754 single-precision word.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   input handshake
//   in_sign, in_exp     result sign, signed pre-normalization biased exponent
//   in_mant, in_class   raw 1.m x 1.m product, operand class
//   out_valid/out_ready output handshake
//   out_result          packed single-precision result
//   out_flags           {invalid, overflow, underflow, inexact}
// Macro FP_MULT_SUBNORM_EN: gradual underflow instead of flush-to-zero.
module fp_mult_norm_round #(
    parameter int          LAT_STAGES = 2,
    parameter logic [31:0] QNAN       = 32'h7FC0_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [9:0]  in_exp,
    input  logic [47:0] in_mant,
    input  logic [1:0]  in_class,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [3:0]  out_flags
);
    import fp_mult_pkg::*;

    generate
        if (LAT_STAGES != 2) begin : g_lat_check
            $error("fp_mult_norm_round: LAT_STAGES must be 2");
        end
    endgenerate

    logic               s1_v_r;
    logic               s2_v_r;
    s1_t                s1_r;
    s1_t                s1_nxt_s;
    logic [31:0]        out_result_r;
    logic [3:0]         out_flags_r;
    logic               s1_load_s;
    logic               s2_load_s;
    logic signed [9:0]  norm_exp_s;
    logic [22:0]        norm_frac_s;
    logic               norm_guard_s;
    logic               norm_sticky_s;
    logic [22:0]        frac_rnd_s;
    logic               carry_s;
    logic signed [10:0] exp_rnd_s;
    logic [31:0]        res_s;
    logic [3:0]         flg_s;
`ifdef FP_MULT_SUBNORM_EN
    logic [4:0]         den_sh_s;
    logic [49:0]        den_ext_s;
`endif

    // s2 drains whenever it is empty or its result is being taken; s1 refills behind it.
    assign s2_load_s  = ~s2_v_r | out_ready;
    assign s1_load_s  = ~s1_v_r | s2_load_s;
    assign in_ready   = s1_load_s;
    assign out_valid  = s2_v_r;
    assign out_result = out_result_r;
    assign out_flags  = out_flags_r;

    // Stage 1: align the product so the hidden one sits just above the fraction.
    always_comb begin
        norm_exp_s    = $signed(in_exp);
        norm_frac_s   = in_mant[45:23];
        norm_guard_s  = in_mant[22];
        norm_sticky_s = |in_mant[21:0];
        if (in_mant[47]) begin
            norm_exp_s    = $signed(in_exp) + 10'sd1;
            norm_frac_s   = in_mant[46:24];
            norm_guard_s  = in_mant[23];
            norm_sticky_s = |in_mant[22:0];
        end else begin
            norm_exp_s    = $signed(in_exp);
        end
    end

    // Stage 1: assemble the register image, denormalizing tiny results when enabled.
    always_comb begin
        s1_nxt_s        = '0;
        s1_nxt_s.sign   = in_sign;
        s1_nxt_s.cls    = in_class;
        s1_nxt_s.exp    = norm_exp_s;
        s1_nxt_s.frac   = norm_frac_s;
        s1_nxt_s.guard  = norm_guard_s;
        s1_nxt_s.sticky = norm_sticky_s;
`ifdef FP_MULT_SUBNORM_EN
        den_sh_s  = 5'd0;
        den_ext_s = 50'd0;
        if (norm_exp_s <= 10'sd0) begin
            // Shift amount is 1-exp; anything past 25 leaves only sticky bits.
            if (norm_exp_s < -10'sd23) begin
                den_sh_s = 5'd25;
            end else begin
                den_sh_s = 5'(10'sd1 - norm_exp_s);
            end
            den_ext_s       = {1'b1, norm_frac_s, norm_guard_s, 25'd0} >> den_sh_s;
            s1_nxt_s.exp    = 10'sd0;
            s1_nxt_s.frac   = den_ext_s[48:26];
            s1_nxt_s.guard  = den_ext_s[25];
            s1_nxt_s.sticky = norm_sticky_s | (|den_ext_s[24:0]);
        end else begin
            den_sh_s = 5'd0;
        end
`endif
    end

    fp_rne_round u_rne (
        .frac     (s1_r.frac),
        .guard    (s1_r.guard),
        .sticky   (s1_r.sticky),
        .frac_rnd (frac_rnd_s),
        .carry    (carry_s)
    );

    assign exp_rnd_s = $signed({s1_r.exp[9], s1_r.exp}) + $signed({10'd0, carry_s});

    // Stage 2: specials bypass rounding; normals round, then check range.
    always_comb begin
        res_s = 32'd0;
        flg_s = 4'd0;
        case (s1_r.cls)
            CLS_ZERO: res_s = {s1_r.sign, 31'd0};
            CLS_INF:  res_s = {s1_r.sign, 8'hFF, 23'd0};
            CLS_INV: begin
                res_s          = QNAN;
                flg_s[FLG_INV] = 1'b1;
            end
            default: begin
`ifdef FP_MULT_SUBNORM_EN
                if (s1_r.exp == 10'sd0) begin
                    // Subnormal field; a carry into bit 23 becomes exponent 1.
                    res_s          = {s1_r.sign, 7'd0, carry_s, frac_rnd_s};
                    flg_s[FLG_INX] = s1_r.guard | s1_r.sticky;
                    flg_s[FLG_UDF] = s1_r.guard | s1_r.sticky;
                end else if (exp_rnd_s >= EXP_MAX) begin
`else
                if ($signed(s1_r.exp) <= 10'sd0) begin
                    res_s          = {s1_r.sign, 31'd0};
                    flg_s[FLG_UDF] = 1'b1;
                    flg_s[FLG_INX] = 1'b1;
                end else if (exp_rnd_s >= EXP_MAX) begin
`endif
                    res_s          = {s1_r.sign, 8'hFF, 23'd0};
                    flg_s[FLG_OVF] = 1'b1;
                    flg_s[FLG_INX] = 1'b1;
                end else begin
                    res_s          = {s1_r.sign, exp_rnd_s[7:0], frac_rnd_s};
                    flg_s[FLG_INX] = s1_r.guard | s1_r.sticky;
                end
            end
        endcase
    end

    // Pipeline valid bits, stage-1 register and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_r       <= 1'b0;
            s2_v_r       <= 1'b0;
            s1_r         <= '0;
            out_result_r <= 32'd0;
            out_flags_r  <= 4'd0;
        end else begin
            if (s1_load_s) begin
                s1_v_r <= in_valid;
                if (in_valid) begin
                    s1_r <= s1_nxt_s;
                end
            end
            if (s2_load_s) begin
                s2_v_r <= s1_v_r;
                if (s1_v_r) begin
                    out_result_r <= res_s;
                    out_flags_r  <= flg_s;
                end
            end
        end
    end

endmodule

// File: tb/tb_fp_mult_norm_round.sv
// Self-checking bench for fp_mult_norm_round: directed vector table, random
// stream against an exact-arithmetic reference, backpressure and reset cases.
module tb_fp_mult_norm_round;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [9:0]  in_exp;
    logic [47:0] in_mant;
    logic [1:0]  in_class;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [3:0]  out_flags;

    int pass_cnt = 0;
    int chk_cnt  = 0;
    logic mon_en = 1'b0;
    logic [35:0] sb[$];

    fp_mult_norm_round dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sign    (in_sign),
        .in_exp     (in_exp),
        .in_mant    (in_mant),
        .in_class   (in_class),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Exact-arithmetic reference: integer quotient/remainder rounding, returns {result, flags}.
    function automatic logic [35:0] ref_model(logic s, logic [9:0] e_in, logic [47:0] m, logic [1:0] c);
        int e, pos, sh;
        longint unsigned mm, q, rem, half;
        logic inx;
        logic [31:0] r;
        case (c)
            2'b01:   return {s, 31'd0, 4'b0000};
            2'b10:   return {s, 8'hFF, 23'd0, 4'b0000};
            2'b11:   return {32'h7FC00000, 4'b1000};
            default: ;
        endcase
        mm  = {16'd0, m};
        pos = m[47] ? 47 : 46;
        e   = int'($signed(e_in)) + pos - 46;
`ifndef FP_MULT_SUBNORM_EN
        if (e <= 0) return {s, 31'd0, 4'b0011};
        sh = pos - 23;
`else
        sh = pos - 23 + ((e <= 0) ? (1 - e) : 0);
`endif
        if (sh > 50) begin
            q = 0; inx = 1'b1;
        end else begin
            q    = mm >> sh;
            rem  = mm & ((64'd1 << sh) - 64'd1);
            half = 64'd1 << (sh - 1);
            if (rem > half || (rem == half && q[0])) q = q + 1;
            inx = (rem != 0);
        end
        if (e <= 0) begin
            r = {s, 8'(q >> 23), q[22:0]};
            return {r, 1'b0, 1'b0, inx, inx};
        end
        if (q == (64'd1 << 24)) begin
            q = 64'd1 << 23; e = e + 1;
        end
        if (e >= 255) return {s, 8'hFF, 23'd0, 4'b0101};
        r = {s, e[7:0], q[22:0]};
        return {r, 3'b000, inx};
    endfunction

    task automatic rand_beat();
        logic [63:0] r64;
        int e;
        r64 = {$urandom, $urandom};
        if ($urandom_range(0, 1) == 1) r64[47] = 1'b1;
        else begin r64[47] = 1'b0; r64[46] = 1'b1; end
        if ($urandom_range(0, 3) == 0) r64[21:0] = 22'd0;
        e        = int'($urandom_range(0, 340)) - 40;
        in_exp   = e[9:0];
        in_mant  = r64[47:0];
        in_sign  = 1'($urandom);
        in_class = ($urandom_range(0, 9) < 8) ? 2'b00 : 2'($urandom_range(1, 3));
    endtask

    // Scoreboard: record accepted beats, compare each consumed result in order.
    always @(negedge clk) begin
        if (mon_en) begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) chk("sb_unexpected_out", 64'(out_valid), 64'd0);
                else begin
                    logic [35:0] e;
                    e = sb.pop_front();
                    chk("sb_result", 64'(out_result), 64'(e[35:4]));
                    chk("sb_flags", 64'(out_flags), 64'(e[3:0]));
                end
            end
            if (in_valid && in_ready) sb.push_back(ref_model(in_sign, in_exp, in_mant, in_class));
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    typedef struct packed {
        logic        s;
        logic [9:0]  e;
        logic [47:0] m;
        logic [1:0]  c;
        logic [31:0] r;
        logic [3:0]  f;
    } vec_t;

    localparam int NV = 10;
    vec_t tbl[NV];

    initial begin
        int   n_sent, cyc;
        logic acc;
        logic [31:0] held;

        tbl[0] = '{1'b1, 10'd129, 48'hD90000000000, 2'b00, 32'hC1590000, 4'b0000};
        tbl[1] = '{1'b0, 10'd127, 48'h400000C00000, 2'b00, 32'h3F800002, 4'b0001};
        tbl[2] = '{1'b0, 10'd127, 48'h400000400000, 2'b00, 32'h3F800000, 4'b0001};
        tbl[3] = '{1'b0, 10'd127, 48'h7FFFFFC00000, 2'b00, 32'h40000000, 4'b0001};
        tbl[4] = '{1'b0, 10'd254, 48'h800000000000, 2'b00, 32'h7F800000, 4'b0101};
        tbl[5] = '{1'b1, 10'd5,   48'h123456789ABC, 2'b11, 32'h7FC00000, 4'b1000};
        tbl[6] = '{1'b1, 10'd0,   48'h000000000000, 2'b10, 32'hFF800000, 4'b0000};
        tbl[7] = '{1'b0, 10'd0,   48'h000000000000, 2'b01, 32'h00000000, 4'b0000};
        tbl[8] = '{1'b1, 10'd0,   48'h000000000000, 2'b01, 32'h80000000, 4'b0000};
`ifdef FP_MULT_SUBNORM_EN
        tbl[9] = '{1'b0, 10'd0,   48'h400000000000, 2'b00, 32'h00400000, 4'b0000};
`else
        tbl[9] = '{1'b0, 10'd0,   48'h400000000000, 2'b00, 32'h00000000, 4'b0011};
`endif

        rst = 1'b1; in_valid = 1'b0; in_sign = 1'b0; in_exp = 10'd0;
        in_mant = 48'd0; in_class = 2'b00; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_result", 64'(out_result), 64'd0);
        chk("rst_out_flags", 64'(out_flags), 64'd0);
        @(posedge clk); #1;

        // Directed vectors, one beat at a time, checking the two-cycle latency.
        for (int i = 0; i < NV; i++) begin
            in_sign = tbl[i].s; in_exp = tbl[i].e; in_mant = tbl[i].m; in_class = tbl[i].c;
            in_valid = 1'b1;
            @(posedge clk); #1 in_valid = 1'b0;
            @(negedge clk);
            chk($sformatf("vec%0d_lat1", i), 64'(out_valid), 64'd0);
            @(posedge clk); @(negedge clk);
            chk($sformatf("vec%0d_valid", i), 64'(out_valid), 64'd1);
            chk($sformatf("vec%0d_result", i), 64'(out_result), 64'(tbl[i].r));
            chk($sformatf("vec%0d_flags", i), 64'(out_flags), 64'(tbl[i].f));
            chk($sformatf("vec%0d_model", i), 64'(ref_model(tbl[i].s, tbl[i].e, tbl[i].m, tbl[i].c)),
                64'({tbl[i].r, tbl[i].f}));
            @(posedge clk); #1;
        end

        // Backpressure: out_ready low for three cycles while streaming five beats.
        mon_en = 1'b1; n_sent = 0; cyc = 0; held = 32'd0;
        while (n_sent < 5 && cyc < 40) begin
            if (!in_valid) begin rand_beat(); in_class = 2'b00; in_valid = 1'b1; end
            out_ready = (cyc >= 3);
            @(negedge clk);
            if (cyc == 2) begin
                chk("bp_in_ready_low", 64'(in_ready), 64'd0);
                chk("bp_out_valid", 64'(out_valid), 64'd1);
                held = out_result;
            end
            if (cyc == 3) chk("bp_hold", 64'(out_result), 64'(held));
            acc = in_ready;
            @(posedge clk); #1;
            if (acc) begin n_sent++; in_valid = 1'b0; end
            cyc++;
        end
        chk("bp_sent", 64'(n_sent), 64'd5);
        in_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 20 && sb.size() != 0; k++) @(posedge clk);
        #1 chk("bp_drain", 64'(sb.size()), 64'd0);

        // Random stream with random stalls on both sides.
        n_sent = 0;
        for (int c = 0; c < 1500 && n_sent < 300; c++) begin
            if (!in_valid && $urandom_range(0, 9) < 7) begin rand_beat(); in_valid = 1'b1; end
            out_ready = ($urandom_range(0, 9) < 7);
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) begin n_sent++; in_valid = 1'b0; end
        end
        chk("rand_sent", 64'(n_sent), 64'd300);
        in_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 20 && sb.size() != 0; k++) @(posedge clk);
        #1 chk("rand_drain", 64'(sb.size()), 64'd0);

        // Reset with both stages full discards everything in flight.
        mon_en = 1'b0; sb.delete(); out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            rand_beat(); in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        chk("full_out_valid", 64'(out_valid), 64'd1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        chk("mid_rst_result", 64'(out_result), 64'd0);
        chk("mid_rst_flags", 64'(out_flags), 64'd0);
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("post_rst_idle%0d", k), 64'(out_valid), 64'd0);
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
